instr_fetch_ctrl: RTL
=====================

// Module: instr_fetch_ctrl
// PURPOSE
//  Sequences the word-indexed instruction memory for the processor front end. Owns the PC,
//  drives the memory address, holds it stable MEM_LATENCY cycles (memory output is delayed),
//  captures the word and queues {pc,instr} pairs to decode over a valid/ready handshake.
//  Handles decode back-pressure, branch/jump redirect with flush, and fetch enable/halt.
// PARAMETERS
//  MEM_LATENCY  2     cycles address must be stable before imem_rdata is sampled (>=1)
//  MEM_DEPTH    1024  instruction memory depth in words; PC wraps modulo MEM_DEPTH
//  RESET_PC     0     word index fetched first after reset
//  QDEPTH       2     fetch queue entries (power of two, >=2)
// PORTS
//  clk             in   1   single clock, rising edge
//  reset           in   1   synchronous, active-high
//  fetch_en        in   1   1 = fetch; 0 = finish in-flight fetch then idle
//  imem_addr       out  32  word index to instruction memory (no /4 scaling)
//  imem_rdata      in   32  instruction word from memory
//  redirect_valid  in   1   branch/jump taken; one-cycle pulse
//  redirect_pc     in   32  new word index; low log2(MEM_DEPTH) bits used
//  out_valid       out  1   queue head valid
//  out_instr       out  32  queue head instruction
//  out_pc          out  32  word index of out_instr
//  out_ready       in   1   decode accepts head when out_valid&out_ready
// BEHAVIOUR
//  - Reset: pc=RESET_PC, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, queue empty,
//    lat_cnt=0, state IDLE. Reset mid-fetch discards in-flight word; no partial capture.
//  - imem_addr is the pc register directly (registered output, no combinational path).
//  - FSM IDLE: fetch_en=1 -> WAIT, lat_cnt=MEM_LATENCY-1. Otherwise stay.
//  - FSM WAIT: lat_cnt>0 -> decrement. lat_cnt==0 -> capture edge: if queue has a slot
//    (not full, or full with pop this cycle) push {pc,imem_rdata}, pc<=(pc+1)%MEM_DEPTH,
//    then fetch_en ? reload lat_cnt=MEM_LATENCY-1, stay WAIT : go IDLE.
//    If no slot: hold pc/address, stay WAIT with lat_cnt=0 (data remains valid), retry.
//  - Throughput: one instruction per MEM_LATENCY cycles when decode never stalls.
//    MEM_LATENCY=1: capture every cycle; first out_valid 1 cycle after leaving IDLE.
//  - Redirect (highest priority, any state): flush queue (out_valid=0 next cycle, even if
//    a pop is also signalled), discard in-flight word, pc<=redirect_pc%MEM_DEPTH,
//    lat_cnt=MEM_LATENCY-1, next state WAIT if fetch_en else IDLE. A capture due the same
//    cycle is dropped. Redirect to the current pc still restarts the latency count.
//  - Queue: FIFO order, push and pop same cycle when full is legal (count unchanged);
//    pop when empty ignored. out_* stable while out_valid&!out_ready.
//  - fetch_en deasserted in WAIT: current fetch completes and is pushed, then IDLE;
//    queue contents remain poppable.
//  - Wrap: pc=MEM_DEPTH-1 increments to 0; out_pc reports MEM_DEPTH-1 for that word.
// STRUCTURE
//  - fetch_pkg: state enum {IDLE,WAIT}, fetch_entry_t struct {pc[31:0],instr[31:0]},
//    default MEM_DEPTH/RESET_PC constants shared with the memory and PC-select logic.
//  - Sub-module fetch_queue (QDEPTH-entry synchronous FIFO of fetch_entry_t with
//    push/pop/flush/full/empty); FSM, pc and latency counter stay in instr_fetch_ctrl.
// TESTING (memory model: word[i]=32'h100+i, combinational with MEM_LATENCY delay)
//  1 Reset, MEM_LATENCY=2, fetch_en=1, out_ready=1 -> out {pc,instr}={0,0x100},{1,0x101},..
//    one every 2 cycles; first out_valid 2 cycles after leaving IDLE; outputs 0 during reset.
//  2 out_ready=0 for 10 cycles -> queue holds {0,0x100},{1,0x101}; imem_addr stuck at 2;
//    release -> 0x102 delivered next, no loss/duplication.
//  3 redirect_valid with redirect_pc=40 while queue full and fetch in flight -> out_valid=0
//    next cycle; next delivered {40,0x128}, then {41,0x129}.
//  4 redirect_pc=MEM_DEPTH-1 -> delivered {1023,0x4FF} then {0,0x100} (wrap).
//  5 fetch_en dropped mid-WAIT -> exactly one more word pushed, state IDLE, addr frozen;
//    reassert -> fetch resumes at next pc.
//  6 MEM_LATENCY=1, reset asserted mid-stream -> queue empty, imem_addr=RESET_PC next
//    cycle; after release stream restarts at {0,0x100}, one instr per cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_pkg
// Purpose : Shared types and default constants for the instruction fetch path.
// Revision: 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int c_MEM_DEPTH_DEFAULT = 1024;
    localparam int c_RESET_PC_DEFAULT  = 0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : fetch_queue
// Purpose : QDEPTH-entry synchronous FIFO of {pc,instr} entries with flush.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  fetch_entry_t i_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output fetch_entry_t o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int c_PTR_W = $clog2(QDEPTH);

    fetch_entry_t         r_mem [QDEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic                 w_pop;
    logic                 w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (c_PTR_W+1)'(QDEPTH));
    assign o_head  = r_mem[r_rd_ptr];

    // A push into a full queue is accepted when the head leaves in the same cycle.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_ctrl
// Purpose : PC owner and fetch sequencer; waits out memory latency and queues
//           {pc,instr} pairs to decode, with redirect/flush and fetch enable.
// Revision: 1.0 - initial release
// ============================================================================
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int MEM_DEPTH   = c_MEM_DEPTH_DEFAULT,
    parameter int RESET_PC    = c_RESET_PC_DEFAULT,
    parameter int QDEPTH      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
);

    localparam int                 c_LAT_W      = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [c_LAT_W-1:0] c_LAT_RELOAD = c_LAT_W'(MEM_LATENCY - 1);
    localparam logic [31:0]        c_DEPTH      = 32'(MEM_DEPTH);
    localparam logic [31:0]        c_RESET_PC   = 32'(RESET_PC % MEM_DEPTH);

    fetch_state_t         r_state;
    logic [31:0]          r_pc;
    logic [c_LAT_W-1:0]   r_lat_cnt;

    logic                 w_capture_due;
    logic                 w_pop;
    logic                 w_slot;
    logic                 w_push;
    logic                 w_full;
    logic                 w_empty;
    logic [31:0]          w_pc_next;
    logic [31:0]          w_redirect_pc;
    fetch_entry_t         w_push_data;
    fetch_entry_t         w_head;

    assign imem_addr     = r_pc;
    assign w_capture_due = (r_state == WAIT) && (r_lat_cnt == '0);
    assign w_pop         = out_ready & out_valid;
    assign w_slot        = ~w_full | w_pop;
    // A redirect in the capture cycle kills the word fetched from the old path.
    assign w_push        = w_capture_due & w_slot & ~redirect_valid;
    assign w_pc_next     = (r_pc == c_DEPTH - 32'd1) ? '0 : r_pc + 32'd1;
    assign w_redirect_pc = redirect_pc % c_DEPTH;
    assign w_push_data   = '{pc: r_pc, instr: imem_rdata};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pc      <= c_RESET_PC;
            r_lat_cnt <= '0;
        end else if (redirect_valid) begin
            r_pc      <= w_redirect_pc;
            r_lat_cnt <= c_LAT_RELOAD;
            r_state   <= fetch_en ? WAIT : IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (fetch_en) begin
                        r_state   <= WAIT;
                        r_lat_cnt <= c_LAT_RELOAD;
                    end
                end
                WAIT: begin
                    if (r_lat_cnt != '0) begin
                        r_lat_cnt <= r_lat_cnt - c_LAT_W'(1);
                    end else if (w_slot) begin
                        r_pc <= w_pc_next;
                        if (fetch_en) begin
                            r_lat_cnt <= c_LAT_RELOAD;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (out_ready),
        .i_flush (redirect_valid),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid = ~w_empty;
    assign out_pc    = w_head.pc;
    assign out_instr = w_head.instr;

endmodule
`default_nettype wire
